// File: rtl/nibble_serial_subtractor_pkg.sv
// rtl/nibble_serial_subtractor_pkg.sv - shared types and helpers for the nibble-serial subtractor
package nbs_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } nbs_state_t;

    function automatic int nibble_count(input int width);
        return width / 4;
    endfunction

endpackage

// File: rtl/nibble_serial_subtractor_cla4.sv
// rtl/nibble_serial_subtractor_cla4.sv - 4-bit carry-lookahead adder slice
module CarryLookAheadAdder4Bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       c_out
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Carries are flattened from generate/propagate so no ripple path exists.
    assign c[0] = c_in;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign s     = p ^ c[3:0];
    assign c_out = c[4];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// rtl/nibble_serial_subtractor.sv - WIDTH-bit a - b - borrow_in, one nibble per clock
module nibble_serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);
    import nbs_pkg::*;

    localparam int NIBBLES = nibble_count(WIDTH);
    localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    generate
        if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_width_check
            $error("nibble_serial_subtractor: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    nbs_state_t      state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             borrow_q;
    logic             ovf_q;

    logic [3:0] a_nib;
    logic [3:0] b_nib;
    logic [3:0] b_inv;
    logic [3:0] sum;
    logic       c_out;

    always_comb begin
        a_nib = 4'h0;
        b_nib = 4'h0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (cnt == CW'(i)) begin
                a_nib = a_q[4*i +: 4];
                b_nib = b_q[4*i +: 4];
            end
        end
    end

    // Subtraction as a + ~b + carry, carry seeded with ~borrow_in.
    assign b_inv = ~b_nib;

    CarryLookAheadAdder4Bit u_slice (
        .a     (a_nib),
        .b     (b_inv),
        .c_in  (carry),
        .s     (sum),
        .c_out (c_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        carry <= ~borrow_in;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (cnt == CW'(i)) begin
                            diff_q[4*i +: 4] <= sum;
                        end
                    end
                    carry <= c_out;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        borrow_q <= ~c_out;
                        ovf_q    <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sum[3] != a_q[WIDTH-1]);
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign diff       = diff_q;
    assign borrow_out = borrow_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// tb/tb_nibble_serial_subtractor.sv - self-checking bench for the nibble-serial subtractor
module tb_nibble_serial_subtractor;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        iv16, ir16, ov16, or16, bin16, bo16, ovf16;
    logic [15:0] a16, b16, d16;
    logic        iv4, ir4, ov4, or4, bin4, bo4, ovf4;
    logic [3:0]  a4, b4, d4;

    int errors = 0;
    int checks = 0;

    nibble_serial_subtractor #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .borrow_in(bin16), .out_valid(ov16), .out_ready(or16), .diff(d16),
        .borrow_out(bo16), .overflow(ovf16)
    );

    nibble_serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
        .borrow_in(bin4), .out_valid(ov4), .out_ready(or4), .diff(d4),
        .borrow_out(bo4), .overflow(ovf4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic void ref_sub(input int w, input int a, input int b, input int bin,
                                    output int d, output bit bo, output bit ov);
        int full, sa, sb, sr;
        full = 1 << w;
        d  = (a - b - bin) & (full - 1);
        bo = (a < b + bin);
        sa = (a >= full / 2) ? a - full : a;
        sb = (b >= full / 2) ? b - full : b;
        sr = sa - sb - bin;
        ov = (sr < -(full / 2)) || (sr > full / 2 - 1);
    endfunction

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic bin,
                        input int hold, input logic [15:0] ed, input logic ebo, input logic eov,
                        input bit chk_lat);
        int n;
        check("in_ready_idle16", 32'(ir16), 32'd1);
        a16 = a; b16 = b; bin16 = bin; iv16 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0;
        n = 0;
        while (!ov16 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("out_valid_timeout16", 32'(ov16), 32'd1);
        if (chk_lat) check("latency16", 32'(n), 32'd4);
        for (int h = 0; h < hold; h++) begin
            a16 = 16'hDEAD; b16 = 16'h0BEE; iv16 = 1'b1;
            @(posedge clk); #1;
            check("hold_valid", 32'(ov16), 32'd1);
            check("hold_in_ready", 32'(ir16), 32'd0);
            check("hold_diff", 32'(d16), 32'(ed));
            check("hold_borrow", 32'(bo16), 32'(ebo));
        end
        iv16 = 1'b0;
        or16 = 1'b1;
        check("diff16", 32'(d16), 32'(ed));
        check("borrow16", 32'(bo16), 32'(ebo));
        check("overflow16", 32'(ovf16), 32'(eov));
        @(posedge clk); #1;
        or16 = 1'b0;
        check("post_valid16", 32'(ov16), 32'd0);
        check("post_diff_hold16", 32'(d16), 32'(ed));
    endtask

    task automatic op4(input int a, input int b, input int bin);
        int n, ed;
        bit ebo, eov;
        ref_sub(4, a, b, bin, ed, ebo, eov);
        a4 = 4'(a); b4 = 4'(b); bin4 = 1'(bin); iv4 = 1'b1;
        @(posedge clk); #1;
        iv4 = 1'b0;
        n = 0;
        while (!ov4 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency4", 32'(n), 32'd1);
        or4 = 1'b1;
        check("diff4", 32'(d4), 32'(ed));
        check("borrow4", 32'(bo4), 32'(ebo));
        check("overflow4", 32'(ovf4), 32'(eov));
        @(posedge clk); #1;
        or4 = 1'b0;
    endtask

    initial begin
        int rd, ra, rb, rbin;
        bit rbo, rov;
        rst_n = 1'b0;
        iv16 = 0; or16 = 0; a16 = 0; b16 = 0; bin16 = 0;
        iv4 = 0; or4 = 0; a4 = 0; b4 = 0; bin4 = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(ir16), 32'd1);
        check("rst_out_valid", 32'(ov16), 32'd0);
        check("rst_diff", 32'(d16), 32'd0);
        check("rst_borrow", 32'(bo16), 32'd0);
        check("rst_overflow", 32'(ovf16), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        op16(16'h1234, 16'h0234, 1'b0, 0, 16'h1000, 1'b0, 1'b0, 1'b1);
        op16(16'h0000, 16'h0001, 1'b0, 0, 16'hFFFF, 1'b1, 1'b0, 1'b1);
        op16(16'h8000, 16'h0001, 1'b0, 0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        op16(16'h7FFF, 16'hFFFF, 1'b0, 0, 16'h8000, 1'b1, 1'b1, 1'b0);
        op16(16'h0005, 16'h0005, 1'b1, 3, 16'hFFFF, 1'b1, 1'b0, 1'b0);

        // Abort during the second RUN cycle.
        a16 = 16'h4321; b16 = 16'h1111; bin16 = 1'b0; iv16 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", 32'(ir16), 32'd1);
        check("abort_out_valid", 32'(ov16), 32'd0);
        check("abort_diff", 32'(d16), 32'd0);
        check("abort_borrow", 32'(bo16), 32'd0);
        check("abort_overflow", 32'(ovf16), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        op16(16'h00FF, 16'h000F, 1'b0, 0, 16'h00F0, 1'b0, 1'b0, 1'b1);

        for (int k = 0; k < 40; k++) begin
            ra = int'($urandom_range(0, 65535));
            rb = int'($urandom_range(0, 65535));
            rbin = int'($urandom_range(0, 1));
            ref_sub(16, ra, rb, rbin, rd, rbo, rov);
            op16(16'(ra), 16'(rb), 1'(rbin), int'($urandom_range(0, 2)), 16'(rd), rbo, rov, 1'b1);
        end

        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                for (int c = 0; c < 2; c++)
                    op4(x, y, c);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
